// File: rtl/shared_bank_serializer.sv
// -----------------------------------------------------------------------------
// shared_bank_serializer
//
// Purpose:
//   Takes one warp-wide (32-lane) memory access packet and replays it as a
//   sequence of passes onto 16 single-ported banks. In every pass each bank
//   serves the lowest-indexed pending lane that maps to it, so conflicting
//   lanes are serialized in ascending lane order. A packet produces as many
//   passes as the worst bank conflict. An empty mask still produces exactly
//   one pass, so the requester always sees a last_o.
//
//   Optional feature, enabled by defining the macro SHARED_BCAST_EN:
//   in load passes, every pending lane reading the same word as the lane
//   granted on a bank is served in that same pass (broadcast). Stores never
//   broadcast. Without the macro, each bank serves exactly one lane per pass.
//
// Handshake:
//   pkt_valid_i / pkt_ready_o: a packet is taken on a rising edge where both
//   are 1. pkt_ready_o is 1 only while idle, out of reset and not stalled;
//   the offering side must hold the packet stable until it is taken.
//   stall=1 freezes every register, outputs included.
//
// Ports:
//   clk, reset (sync, active-low), stall
//   pkt_valid_i, pkt_ready_o, pkt_load_i, pkt_warp_i, pkt_mask_i (bit 31 =
//   lane 0), pkt_addr_i / pkt_data_i (lane 0 in the most-significant slice)
//   bank_valid_o, bank_addr_o, bank_wdata_o (bank 0 in the least-significant
//   slice), bank_we_o, grant_mask_o, warp_o, last_o, pass_cnt_o (1-based)
//   dbg_state_o : current FSM state (0 = IDLE, 1 = REPLAY)
// -----------------------------------------------------------------------------
module shared_bank_serializer #(
    parameter int SIZE_ADDR    = 32,
    parameter int SIZE_DATA    = 32,
    parameter int NUM_WARP_LOG = 5
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      stall,
    input  logic                      pkt_valid_i,
    output logic                      pkt_ready_o,
    input  logic                      pkt_load_i,
    input  logic [NUM_WARP_LOG-1:0]   pkt_warp_i,
    input  logic [31:0]               pkt_mask_i,
    input  logic [32*SIZE_ADDR-1:0]   pkt_addr_i,
    input  logic [32*SIZE_DATA-1:0]   pkt_data_i,
    output logic [15:0]               bank_valid_o,
    output logic [16*SIZE_ADDR-1:0]   bank_addr_o,
    output logic [16*SIZE_DATA-1:0]   bank_wdata_o,
    output logic                      bank_we_o,
    output logic [31:0]               grant_mask_o,
    output logic [NUM_WARP_LOG-1:0]   warp_o,
    output logic                      last_o,
    output logic [5:0]                pass_cnt_o,
    output logic                      dbg_state_o
);

    typedef enum logic {
        ST_IDLE   = 1'b0,
        ST_REPLAY = 1'b1
    } state_t;

    state_t r_state;
    state_t w_state_next;

    // Latched packet
    logic                     r_load;
    logic [NUM_WARP_LOG-1:0]  r_warp;
    logic [32*SIZE_ADDR-1:0]  r_addr;
    logic [32*SIZE_DATA-1:0]  r_data;
    logic [31:0]              r_pend;     // mask ordering: bit 31 = lane 0
    logic [5:0]               r_npass;    // number the next pass will carry

    logic w_accept;
    logic w_pass;

    // Lane-indexed views (index = lane number)
    logic [SIZE_ADDR-1:0] w_lane_addr [32];
    logic [SIZE_DATA-1:0] w_lane_data [32];
    logic [31:0]          w_lane_pend;
    logic [31:0]          w_lane_grant;

    // Per-bank arbitration result
    logic [15:0] w_bank_hit;
    logic [4:0]  w_bank_sel [16];

    logic [31:0]             w_grant_mask;
    logic [31:0]             w_pend_next;
    logic [16*SIZE_ADDR-1:0] w_bank_addr;
    logic [16*SIZE_DATA-1:0] w_bank_wdata;

    assign pkt_ready_o = reset & ~stall & (r_state == ST_IDLE);
    assign w_accept    = pkt_valid_i & pkt_ready_o;
    assign w_pass      = (r_state == ST_REPLAY) & ~stall;
    assign dbg_state_o = r_state;

    // -------------------------------------------------------------------------
    // Lane unpacking: lane 0 lives in the top slice / mask bit 31.
    // -------------------------------------------------------------------------
    always_comb begin
        for (int l = 0; l < 32; l++) begin
            w_lane_addr[l] = r_addr[(31-l)*SIZE_ADDR +: SIZE_ADDR];
            w_lane_data[l] = r_data[(31-l)*SIZE_DATA +: SIZE_DATA];
            w_lane_pend[l] = r_pend[31-l];
        end
    end

    // -------------------------------------------------------------------------
    // Per-bank priority pick: scan lanes upward, first pending hit wins, which
    // is what orders same-word stores so the highest lane writes last.
    // -------------------------------------------------------------------------
    always_comb begin
        for (int b = 0; b < 16; b++) begin
            w_bank_hit[b] = 1'b0;
            w_bank_sel[b] = 5'd0;
            for (int l = 0; l < 32; l++) begin
                if (!w_bank_hit[b] && w_lane_pend[l] &&
                    (w_lane_addr[l][5:2] == 4'(b))) begin
                    w_bank_hit[b] = 1'b1;
                    w_bank_sel[b] = 5'(l);
                end
            end
        end
    end

    // -------------------------------------------------------------------------
    // Lane grants for this pass.
    // -------------------------------------------------------------------------
    always_comb begin
        logic [3:0] v_bank;
        logic [4:0] v_sel;
        v_bank       = 4'd0;
        v_sel        = 5'd0;
        w_lane_grant = '0;
        for (int l = 0; l < 32; l++) begin
            v_bank = w_lane_addr[l][5:2];
            v_sel  = w_bank_sel[v_bank];
            if (w_lane_pend[l] && w_bank_hit[v_bank]) begin
                if (v_sel == 5'(l)) begin
                    w_lane_grant[l] = 1'b1;
                end
`ifdef SHARED_BCAST_EN
                // Same word as the bank's winner: a load can share the read.
                // Same word implies same bank since bits [5:2] are in the key.
                else if (r_load &&
                         (w_lane_addr[l][SIZE_ADDR-1:2] ==
                          w_lane_addr[v_sel][SIZE_ADDR-1:2])) begin
                    w_lane_grant[l] = 1'b1;
                end
`endif
            end
        end
    end

    always_comb begin
        for (int l = 0; l < 32; l++) begin
            w_grant_mask[31-l] = w_lane_grant[l];
        end
    end

    assign w_pend_next = r_pend & ~w_grant_mask;

    // Bank-side payload of the winning lane; idle banks drive zero.
    always_comb begin
        w_bank_addr  = '0;
        w_bank_wdata = '0;
        for (int b = 0; b < 16; b++) begin
            if (w_bank_hit[b]) begin
                w_bank_addr[b*SIZE_ADDR +: SIZE_ADDR]  = w_lane_addr[w_bank_sel[b]];
                w_bank_wdata[b*SIZE_DATA +: SIZE_DATA] = w_lane_data[w_bank_sel[b]];
            end
        end
    end

    // -------------------------------------------------------------------------
    // FSM
    // -------------------------------------------------------------------------
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            ST_IDLE: begin
                if (w_accept) begin
                    w_state_next = ST_REPLAY;
                end
            end
            ST_REPLAY: begin
                if (w_pass && (w_pend_next == 32'd0)) begin
                    w_state_next = ST_IDLE;
                end
            end
            default: w_state_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Packet payload: only meaningful while replaying, so no reset needed.
    always_ff @(posedge clk) begin
        if (w_accept) begin
            r_load <= pkt_load_i;
            r_warp <= pkt_warp_i;
            r_addr <= pkt_addr_i;
            r_data <= pkt_data_i;
        end
    end

    // -------------------------------------------------------------------------
    // Pending mask, pass counter and registered pass outputs.
    // -------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (!reset) begin
            r_pend       <= '0;
            r_npass      <= '0;
            bank_valid_o <= '0;
            bank_addr_o  <= '0;
            bank_wdata_o <= '0;
            bank_we_o    <= 1'b0;
            grant_mask_o <= '0;
            warp_o       <= '0;
            last_o       <= 1'b0;
            pass_cnt_o   <= '0;
        end else if (!stall) begin
            if (w_accept) begin
                r_pend  <= pkt_mask_i;
                r_npass <= 6'd1;
            end else if (w_pass) begin
                r_pend <= w_pend_next;
                // A packet never exceeds 32 passes; hold rather than wrap.
                if (r_npass != 6'd32) begin
                    r_npass <= r_npass + 6'd1;
                end
            end

            if (w_pass) begin
                bank_valid_o <= w_bank_hit;
                bank_addr_o  <= w_bank_addr;
                bank_wdata_o <= w_bank_wdata;
                bank_we_o    <= ~r_load;
                grant_mask_o <= w_grant_mask;
                warp_o       <= r_warp;
                last_o       <= (w_pend_next == 32'd0);
                pass_cnt_o   <= r_npass;
            end else begin
                // No pass: strobes drop, payload fields keep their last value.
                bank_valid_o <= '0;
                grant_mask_o <= '0;
                last_o       <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_shared_bank_serializer.sv
// -----------------------------------------------------------------------------
// tb_shared_bank_serializer
//
// Bench for shared_bank_serializer. Each packet sent is expanded by a small
// reference model into its expected passes, which go into exp_q; a monitor
// pops one entry for every pass the DUT issues and compares it. Directed
// scenarios cover reset, conflict-free spread, same-address conflicts, store
// ordering, empty mask, stall and reset during replay, then random packets.
// Build with +define+SHARED_BCAST_EN to exercise the broadcast variant.
// -----------------------------------------------------------------------------
module tb_shared_bank_serializer;

    localparam int SA = 32;
    localparam int SD = 32;
    localparam int NW = 5;

`ifdef SHARED_BCAST_EN
    localparam bit BCAST = 1'b1;
`else
    localparam bit BCAST = 1'b0;
`endif

    typedef struct packed {
        logic [15:0]      bv;
        logic [16*SA-1:0] addr;
        logic [16*SD-1:0] wdata;
        logic             we;
        logic [31:0]      grant;
        logic [NW-1:0]    warp;
        logic             last;
        logic [5:0]       pc;
    } exp_t;

    exp_t exp_q[$];

    int checks   = 0;
    int failures = 0;

    // ---------------- clock / reset / DUT ----------------
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic             reset = 1'b0;
    logic             stall = 1'b0;
    logic             pkt_valid_i = 1'b0;
    logic             pkt_ready_o;
    logic             pkt_load_i = 1'b0;
    logic [NW-1:0]    pkt_warp_i = '0;
    logic [31:0]      pkt_mask_i = '0;
    logic [32*SA-1:0] pkt_addr_i = '0;
    logic [32*SD-1:0] pkt_data_i = '0;
    logic [15:0]      bank_valid_o;
    logic [16*SA-1:0] bank_addr_o;
    logic [16*SD-1:0] bank_wdata_o;
    logic             bank_we_o;
    logic [31:0]      grant_mask_o;
    logic [NW-1:0]    warp_o;
    logic             last_o;
    logic [5:0]       pass_cnt_o;
    logic             dbg_state;

    shared_bank_serializer #(
        .SIZE_ADDR(SA), .SIZE_DATA(SD), .NUM_WARP_LOG(NW)
    ) dut (
        .clk(clk), .reset(reset), .stall(stall),
        .pkt_valid_i(pkt_valid_i), .pkt_ready_o(pkt_ready_o),
        .pkt_load_i(pkt_load_i), .pkt_warp_i(pkt_warp_i),
        .pkt_mask_i(pkt_mask_i), .pkt_addr_i(pkt_addr_i),
        .pkt_data_i(pkt_data_i), .bank_valid_o(bank_valid_o),
        .bank_addr_o(bank_addr_o), .bank_wdata_o(bank_wdata_o),
        .bank_we_o(bank_we_o), .grant_mask_o(grant_mask_o),
        .warp_o(warp_o), .last_o(last_o), .pass_cnt_o(pass_cnt_o),
        .dbg_state_o(dbg_state)
    );

    // Inputs as seen by the last rising edge.
    logic s_rst_q   = 1'b0;
    logic s_stall_q = 1'b0;
    always @(posedge clk) begin
        s_rst_q   <= reset;
        s_stall_q <= stall;
    end

    // ---------------- scoreboard monitor ----------------
    always @(negedge clk) begin : monitor
        exp_t e;
        if (s_rst_q && !s_stall_q && (last_o || grant_mask_o != 32'd0)) begin
            if (exp_q.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL unexpected_pass got grant=%h last=%b cnt=%0d expected no pass",
                         grant_mask_o, last_o, pass_cnt_o);
            end else begin
                e = exp_q.pop_front();
                checks++;
                if (bank_valid_o !== e.bv) begin
                    failures++;
                    $display("FAIL bank_valid pass=%0d got=%h exp=%h", e.pc, bank_valid_o, e.bv);
                end
                checks++;
                if (grant_mask_o !== e.grant) begin
                    failures++;
                    $display("FAIL grant_mask pass=%0d got=%h exp=%h", e.pc, grant_mask_o, e.grant);
                end
                checks++;
                if (last_o !== e.last) begin
                    failures++;
                    $display("FAIL last pass=%0d got=%b exp=%b", e.pc, last_o, e.last);
                end
                checks++;
                if (pass_cnt_o !== e.pc) begin
                    failures++;
                    $display("FAIL pass_cnt got=%0d exp=%0d", pass_cnt_o, e.pc);
                end
                checks++;
                if (warp_o !== e.warp || bank_we_o !== e.we) begin
                    failures++;
                    $display("FAIL warp_we pass=%0d got=%0d/%b exp=%0d/%b",
                             e.pc, warp_o, bank_we_o, e.warp, e.we);
                end
                for (int b = 0; b < 16; b++) begin
                    if (e.bv[b]) begin
                        checks++;
                        if (bank_addr_o[b*SA +: SA] !== e.addr[b*SA +: SA]) begin
                            failures++;
                            $display("FAIL bank_addr pass=%0d bank=%0d got=%h exp=%h",
                                     e.pc, b, bank_addr_o[b*SA +: SA], e.addr[b*SA +: SA]);
                        end
                        if (e.we) begin
                            checks++;
                            if (bank_wdata_o[b*SD +: SD] !== e.wdata[b*SD +: SD]) begin
                                failures++;
                                $display("FAIL bank_wdata pass=%0d bank=%0d got=%h exp=%h",
                                         e.pc, b, bank_wdata_o[b*SD +: SD], e.wdata[b*SD +: SD]);
                            end
                        end
                    end
                end
            end
        end
    end

    // ---------------- reference model ----------------
    // Walks lanes upward each pass; the first lane seen on a bank takes it.
    task automatic model_push(input logic ld, input logic [NW-1:0] wp,
                              input logic [31:0] m, input logic [32*SA-1:0] ad,
                              input logic [32*SD-1:0] dt);
        logic [31:0]   pend;
        int            n;
        int            b;
        exp_t          e;
        logic [SA-1:0] a;
        logic [SA-3:0] key [16];
        pend = m;
        n    = 0;
        do begin
            e = '0;
            n++;
            for (int l = 0; l < 32; l++) begin
                if (pend[31-l]) begin
                    a = ad[(31-l)*SA +: SA];
                    b = int'(a[5:2]);
                    if (!e.bv[b]) begin
                        e.bv[b]              = 1'b1;
                        e.addr[b*SA +: SA]   = a;
                        e.wdata[b*SD +: SD]  = dt[(31-l)*SD +: SD];
                        key[b]               = a[SA-1:2];
                        e.grant[31-l]        = 1'b1;
                    end else if (BCAST && ld && key[b] == a[SA-1:2]) begin
                        e.grant[31-l] = 1'b1;
                    end
                end
            end
            pend   = pend & ~e.grant;
            e.we   = !ld;
            e.warp = wp;
            e.last = (pend == 32'd0);
            e.pc   = 6'(n);
            exp_q.push_back(e);
        end while (pend != 32'd0);
    endtask

    // ---------------- driver tasks ----------------
    task automatic send_packet(input logic ld, input logic [NW-1:0] wp,
                               input logic [31:0] m, input logic [32*SA-1:0] ad,
                               input logic [32*SD-1:0] dt);
        int waited;
        model_push(ld, wp, m, ad, dt);
        @(posedge clk); #1;
        pkt_valid_i = 1'b1;
        pkt_load_i  = ld;
        pkt_warp_i  = wp;
        pkt_mask_i  = m;
        pkt_addr_i  = ad;
        pkt_data_i  = dt;
        waited = 0;
        @(negedge clk);
        while (!pkt_ready_o && waited < 200) begin
            @(negedge clk);
            waited++;
        end
        checks++;
        if (pkt_ready_o !== 1'b1) begin
            failures++;
            $display("FAIL accept_timeout got ready=%b exp=1", pkt_ready_o);
        end
        @(posedge clk); #1;
        pkt_valid_i = 1'b0;
    endtask

    task automatic wait_drain();
        int cyc;
        cyc = 0;
        while (exp_q.size() != 0 && cyc < 300) begin
            @(negedge clk);
            cyc++;
        end
        checks++;
        if (exp_q.size() != 0) begin
            failures++;
            $display("FAIL drain_timeout got pending_passes=%0d exp=0", exp_q.size());
            exp_q.delete();
        end
        repeat (2) @(negedge clk);
    endtask

    function automatic logic [32*SA-1:0] addr_linear();
        logic [32*SA-1:0] v;
        for (int i = 0; i < 32; i++) v[(31-i)*SA +: SA] = SA'(4 * i);
        return v;
    endfunction

    function automatic logic [32*SA-1:0] addr_same(input logic [SA-1:0] a);
        logic [32*SA-1:0] v;
        for (int i = 0; i < 32; i++) v[(31-i)*SA +: SA] = a;
        return v;
    endfunction

    function automatic logic [32*SD-1:0] data_index();
        logic [32*SD-1:0] v;
        for (int i = 0; i < 32; i++) v[(31-i)*SD +: SD] = SD'(32'hD000 + i);
        return v;
    endfunction

    // ---------------- scenarios ----------------
    task automatic test_reset();
        reset = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        checks++;
        if (pkt_ready_o !== 1'b0) begin
            failures++;
            $display("FAIL reset_ready got=%b exp=0", pkt_ready_o);
        end
        checks++;
        if (bank_valid_o !== 16'd0 || grant_mask_o !== 32'd0 || last_o !== 1'b0) begin
            failures++;
            $display("FAIL reset_strobes got bv=%h grant=%h last=%b exp=0/0/0",
                     bank_valid_o, grant_mask_o, last_o);
        end
        checks++;
        if (pass_cnt_o !== 6'd0 || warp_o !== '0 || bank_we_o !== 1'b0 ||
            bank_addr_o !== '0 || bank_wdata_o !== '0) begin
            failures++;
            $display("FAIL reset_payload got cnt=%0d warp=%0d we=%b exp=0", pass_cnt_o, warp_o, bank_we_o);
        end
        checks++;
        if (dbg_state !== 1'b0) begin
            failures++;
            $display("FAIL reset_state got=%b exp=0", dbg_state);
        end
        reset = 1'b1;
        @(negedge clk);
        checks++;
        if (pkt_ready_o !== 1'b1) begin
            failures++;
            $display("FAIL ready_after_reset got=%b exp=1", pkt_ready_o);
        end
    endtask

    task automatic test_linear();
        send_packet(1'b1, 5'd3, 32'hFFFF_FFFF, addr_linear(), data_index());
        wait_drain();
    endtask

    task automatic test_same_addr();
        send_packet(1'b1, 5'd7, 32'hFFFF_FFFF, addr_same(32'h100), data_index());
        wait_drain();
    endtask

    task automatic test_store_serial();
        logic [32*SA-1:0] ad;
        logic [32*SD-1:0] dt;
        ad = '0;
        dt = '0;
        ad[(31-0)*SA +: SA] = 32'h40;
        ad[(31-5)*SA +: SA] = 32'h40;
        dt[(31-0)*SD +: SD] = 32'hA;
        dt[(31-5)*SD +: SD] = 32'hB;
        send_packet(1'b0, 5'd12, 32'h8400_0000, ad, dt);
        wait_drain();
        // A load of the same pair: merges only in the broadcast build.
        send_packet(1'b1, 5'd13, 32'h8400_0000, ad, dt);
        wait_drain();
    endtask

    task automatic test_zero_mask();
        send_packet(1'b1, 5'd21, 32'd0, addr_linear(), data_index());
        wait_drain();
        checks++;
        if (pkt_ready_o !== 1'b1) begin
            failures++;
            $display("FAIL zero_mask_ready got=%b exp=1", pkt_ready_o);
        end
    endtask

    task automatic test_stall_idle();
        @(posedge clk); #1;
        stall       = 1'b1;
        pkt_valid_i = 1'b1;
        pkt_load_i  = 1'b1;
        pkt_mask_i  = 32'hFFFF_FFFF;
        pkt_addr_i  = addr_linear();
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            checks++;
            if (pkt_ready_o !== 1'b0) begin
                failures++;
                $display("FAIL stall_idle_ready cycle=%0d got=%b exp=0", k, pkt_ready_o);
            end
        end
        @(posedge clk); #1;
        stall       = 1'b0;
        pkt_valid_i = 1'b0;
        repeat (4) @(negedge clk);
        checks++;
        if (dbg_state !== 1'b0) begin
            failures++;
            $display("FAIL stall_idle_state got=%b exp=0", dbg_state);
        end
    endtask

    task automatic test_stall_replay();
        int cyc;
        send_packet(1'b1, 5'd9, 32'hFFFF_FFFF, addr_linear(), data_index());
        cyc = 0;
        @(negedge clk);
        while (grant_mask_o == 32'd0 && cyc < 20) begin
            @(negedge clk);
            cyc++;
        end
        stall = 1'b1;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            checks++;
            if (grant_mask_o !== 32'hFFFF_0000 || last_o !== 1'b0 ||
                pass_cnt_o !== 6'd1 || bank_valid_o !== 16'hFFFF) begin
                failures++;
                $display("FAIL stall_freeze cycle=%0d got grant=%h last=%b cnt=%0d bv=%h exp ffff0000/0/1/ffff",
                         k, grant_mask_o, last_o, pass_cnt_o, bank_valid_o);
            end
            checks++;
            if (pkt_ready_o !== 1'b0) begin
                failures++;
                $display("FAIL stall_ready cycle=%0d got=%b exp=0", k, pkt_ready_o);
            end
        end
        stall = 1'b0;
        wait_drain();
    endtask

    task automatic test_reset_mid();
        int cyc;
        send_packet(1'b0, 5'd30, 32'hFFFF_FFFF, addr_same(32'h100), data_index());
        cyc = 0;
        @(negedge clk);
        while (pass_cnt_o != 6'd3 && cyc < 40) begin
            @(negedge clk);
            cyc++;
        end
        reset = 1'b0;
        @(negedge clk);
        checks++;
        if (bank_valid_o !== 16'd0 || grant_mask_o !== 32'd0 || last_o !== 1'b0 ||
            pass_cnt_o !== 6'd0 || bank_we_o !== 1'b0 || warp_o !== '0) begin
            failures++;
            $display("FAIL reset_mid_outputs got bv=%h grant=%h last=%b cnt=%0d we=%b exp all 0",
                     bank_valid_o, grant_mask_o, last_o, pass_cnt_o, bank_we_o);
        end
        checks++;
        if (dbg_state !== 1'b0 || pkt_ready_o !== 1'b0) begin
            failures++;
            $display("FAIL reset_mid_state got state=%b ready=%b exp 0/0", dbg_state, pkt_ready_o);
        end
        exp_q.delete();
        reset = 1'b1;
        repeat (6) @(negedge clk);
        checks++;
        if (pkt_ready_o !== 1'b1 || grant_mask_o !== 32'd0) begin
            failures++;
            $display("FAIL reset_mid_after got ready=%b grant=%h exp 1/0", pkt_ready_o, grant_mask_o);
        end
    endtask

    task automatic test_random();
        logic [32*SA-1:0] ad;
        logic [32*SD-1:0] dt;
        logic [31:0]      m;
        for (int p = 0; p < 8; p++) begin
            for (int i = 0; i < 32; i++) begin
                ad[(31-i)*SA +: SA] = SA'($urandom_range(0, 3) * 64 + $urandom_range(0, 3) * 4);
                dt[(31-i)*SD +: SD] = SD'($urandom);
            end
            m = $urandom;
            send_packet(1'($urandom_range(0, 1)), NW'($urandom_range(0, 31)), m, ad, dt);
        end
        wait_drain();
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        test_reset();
        test_linear();
        test_same_addr();
        test_store_serial();
        test_zero_mask();
        test_stall_idle();
        test_stall_replay();
        test_reset_mid();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
